axi_slave_write_engine: RTL and testbench
=========================================

# axi_slave_write_engine

Parametrised AXI write-channel slave that accepts one write burst at a time and converts it into per-beat writes on a simple memory-side port. It supports FIXED/INCR/WRAP address sequencing, memory backpressure, window-based address decode with SLVERR responses, and WLAST/length checking. It sits between the AXI interconnect and any on-chip SRAM or register-file slave, replacing single-beat write handling.

## Interface
- DATA_W, 32: AXI/memory data width (power of two, ≥ 8).
- ADDR_W, 32: address width.
- ID_W, 8: AWID/BID width.
- LEN_W, 8: AWLEN width; burst beats = AWLEN + 1.
- BASE_ADDR, 32'h0: first byte address of the slave window.
- WIN_BYTES, 32'h10000: window size in bytes (power of two).

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETn  in  1  reset; synchronous, active-high, despite the name.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/ADDR_W/LEN_W/3/2  write address.
- AWVALID in 1; AWREADY out 1.
- WDATA/WSTRB/WLAST  in  DATA_W/DATA_W/8/1  write data.
- WVALID in 1; WREADY out 1.
- BID/BRESP  out  ID_W/2  response; BVALID out 1; BREADY in 1.
- mem_addr out ADDR_W; mem_wdata out DATA_W; mem_wstrb out DATA_W/8; mem_we out 1: per-beat write strobe.
- mem_ready  in  1  memory accepts the beat this cycle.
- stall  in  1  blocks new AW acceptance (arbiter hold-off).
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM: IDLE → DATA → RESP → IDLE.
- IDLE: AWREADY = !stall. On AWVALID && AWREADY, capture ID, ADDR, LEN, SIZE, BURST; clear beat counter and error flag; go to DATA.
- DATA: AWREADY = 0; WREADY = mem_ready. A beat is accepted on WVALID && WREADY.
  - mem_we = WVALID && in_window && mem_ready; mem_wstrb = in_window ? WSTRB : 0; mem_addr = current address; mem_wdata = WDATA.
  - Per accepted beat: advance address; increment beat counter.
  - Addressing: FIXED holds the address. INCR adds 1<<SIZE. WRAP adds 1<<SIZE within an aligned block of (LEN+1)<<SIZE bytes and wraps at its upper boundary. Reserved burst type (2'b11) is handled as INCR and sets the error flag.
  - in_window is evaluated per beat: BASE_ADDR ≤ addr < BASE_ADDR+WIN_BYTES. An out-of-window beat is consumed, not written, and sets the error flag.
  - The burst ends on the beat where count == LEN. If WLAST ≠ (count == LEN) on any accepted beat, the error flag is set. An early WLAST does not end the burst.
  - SIZE > log2(DATA_W/8) sets the error flag; address stepping still uses SIZE.
- RESP: BVALID = 1; BID = captured ID; BRESP = error ? 2'b10 (SLVERR) : 2'b00 (OKAY). On BREADY, go to IDLE.
- Outside DATA, WREADY = 0 and mem_we = 0.

## Timing
- Reset values: state IDLE, AWREADY 0 during reset then !stall, WREADY 0, BVALID 0, BID 0, BRESP 0, mem_we 0, mem_wstrb 0, mem_addr 0, mem_wdata 0, busy 0.
- Reset asserted mid-burst: next edge is IDLE; the in-flight burst is dropped with no B response.
- Data-path outputs are combinational from registered address plus live W inputs. The memory write happens in the same cycle as the W handshake.
- Minimum burst latency: AW handshake at cycle 0, first beat accepted at cycle 1, BVALID in the cycle after the last beat. A single-beat write takes 3 cycles when BREADY is held high.
- The BREADY handshake returns the FSM to IDLE. A new AW can be accepted on the next cycle, not the same cycle.
- stall affects only IDLE. Asserting it during DATA or RESP has no effect.
- A W beat presented while in IDLE is not accepted.

## Structure
- Shared package axi_pkg holds:
  - burst constants BURST_FIXED/INCR/WRAP;
  - response constants RESP_OKAY/SLVERR;
  - the write FSM state enum.
- Sub-module axi_burst_addr_gen computes the next address from addr, size, len and burst (combinational, parametrised by ADDR_W/LEN_W).

## Test plan
- Single write: AWADDR=0x10, LEN=0, SIZE=2, INCR, WSTRB=4'hF, WDATA=0xDEADBEEF → one mem_we with mem_addr=0x10; BRESP=OKAY; BID equals AWID.
- INCR burst: AWADDR=0x100, LEN=3, SIZE=2 → mem_addr sequence 0x100, 0x104, 0x108, 0x10C; BVALID one cycle after the 4th beat.
- WRAP burst: AWADDR=0x38, LEN=3, SIZE=2 → sequence 0x38, 0x3C, 0x30, 0x34.
- Backpressure: mem_ready low for 2 cycles mid-burst → WREADY low for those cycles, no lost or duplicated beat, same address sequence.
- Errors:
  - AWADDR = BASE_ADDR+WIN_BYTES → mem_we never asserts; BRESP=SLVERR.
  - LEN=1 with WLAST on the 1st beat → 2 beats consumed; BRESP=SLVERR.
- stall=1 with AWVALID held → AWREADY=0 until stall drops. Reset asserted in DATA → busy=0 and BVALID=0 on the next edge.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI write-path constants and the write FSM state type.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StResp
  } wr_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts; reserved burst type steps like INCR.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] incr_addr;

  always_comb begin
    step      = ADDR_W'(1) << size;
    // Wrap block is (len+1)<<size bytes; legal WRAP lengths make this a power of two.
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    incr_addr = addr + step;
    unique case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_slave_write_engine.sv
// AXI write slave: one burst at a time, split into per-beat memory writes with decode/WLAST checks.
module axi_slave_write_engine
  import axi_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       ID_W      = 8,
  parameter int unsigned       LEN_W     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(32'h10000)
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_we,
  input  logic                mem_ready,
  input  logic                stall,
  output logic                busy
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam logic [2:0]  MAX_SIZE = 3'($clog2(STRB_W));

  wr_state_e         state_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              err_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              busy_q;

  logic              aw_hs;
  logic              w_hs;
  logic              last_beat;
  logic              in_window;
  logic              beat_err;
  logic              aw_err;
  logic [ADDR_W-1:0] win_off;
  logic [ADDR_W-1:0] next_addr;

  axi_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both bounds.
  assign win_off   = addr_q - BASE_ADDR;
  assign in_window = win_off < WIN_BYTES;

  assign AWREADY   = (state_q == StIdle) && !stall && !ARESETn;
  assign WREADY    = (state_q == StData) && mem_ready;
  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;
  assign last_beat = (cnt_q == len_q);
  assign beat_err  = !in_window || (WLAST != last_beat);
  assign aw_err    = (AWBURST == BURST_RSVD) || (AWSIZE > MAX_SIZE);

  assign mem_addr  = addr_q;
  assign mem_we    = w_hs && in_window;
  assign mem_wstrb = ((state_q == StData) && in_window) ? WSTRB : '0;
  assign mem_wdata = (state_q == StData) ? WDATA : '0;

  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign BID       = id_q;
  assign busy      = busy_q;

  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      state_q  <= StIdle;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= BURST_FIXED;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (aw_hs) begin
            id_q    <= AWID;
            addr_q  <= AWADDR;
            len_q   <= AWLEN;
            size_q  <= AWSIZE;
            burst_q <= AWBURST;
            cnt_q   <= '0;
            err_q   <= aw_err;
            busy_q  <= 1'b1;
            state_q <= StData;
          end
        end
        StData: begin
          if (w_hs) begin
            addr_q <= next_addr;
            cnt_q  <= cnt_q + LEN_W'(1);
            if (beat_err) begin
              err_q <= 1'b1;
            end
            // An early WLAST is only an error; the burst always runs to AWLEN+1 beats.
            if (last_beat) begin
              bvalid_q <= 1'b1;
              bresp_q  <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
              state_q  <= StResp;
            end
          end
        end
        StResp: begin
          if (BREADY) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: begin
          bvalid_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_write_engine.sv
// Self-checking bench: burst-level reference model compared every cycle, plus directed literal checks.
module tb_axi_slave_write_engine;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned IW   = 8;
  localparam int unsigned LW   = 8;
  localparam longint      BASE = 64'h0;
  localparam longint      WIN  = 64'h10000;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b1;
  logic [IW-1:0] AWID = '0;
  logic [AW-1:0] AWADDR = '0;
  logic [LW-1:0] AWLEN = '0;
  logic [2:0]    AWSIZE = '0;
  logic [1:0]    AWBURST = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          WLAST = 1'b0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [IW-1:0] BID;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_we;
  logic          mem_ready = 1'b1;
  logic          stall = 1'b0;
  logic          busy;

  axi_slave_write_engine #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .ID_W      (IW),
    .LEN_W     (LW),
    .BASE_ADDR (32'h0),
    .WIN_BYTES (32'h10000)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .AWID      (AWID),
    .AWADDR    (AWADDR),
    .AWLEN     (AWLEN),
    .AWSIZE    (AWSIZE),
    .AWBURST   (AWBURST),
    .AWVALID   (AWVALID),
    .AWREADY   (AWREADY),
    .WDATA     (WDATA),
    .WSTRB     (WSTRB),
    .WLAST     (WLAST),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .BID       (BID),
    .BRESP     (BRESP),
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .stall     (stall),
    .busy      (busy)
  );

  always #5 ACLK = ~ACLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Address of beat i, straight from the burst rules.
  function automatic longint beat_addr(longint addr, int len, int size, int burst, int i);
    longint step  = longint'(1) << size;
    longint bytes = (len + 1) * step;
    longint lower = (addr / bytes) * bytes;
    longint a     = addr;
    for (int k = 0; k < i; k++) begin
      if (burst == 0) begin
        a = a;
      end else if (burst == 2) begin
        a = a + step;
        if (a >= lower + bytes) a = lower;
      end else begin
        a = (a + step) & 64'hFFFF_FFFF;
      end
    end
    return a;
  endfunction

  function automatic bit in_win(longint a);
    return (a >= BASE) && (a < BASE + WIN);
  endfunction

  // Reference model: 0 = waiting for AW, 1 = taking beats, 2 = holding a response.
  int          m_mode = 0;
  longint      m_addr0;
  int          m_len, m_size, m_burst, m_beat;
  bit          m_err;
  logic [7:0]  m_id;
  longint      m_cur;

  always @(posedge ACLK) begin
    cyc++;
    if (ARESETn) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (AWVALID && !stall) begin
          m_id    = AWID;
          m_addr0 = longint'(AWADDR);
          m_len   = int'(AWLEN);
          m_size  = int'(AWSIZE);
          m_burst = int'(AWBURST);
          m_beat  = 0;
          m_err   = (AWBURST == 2'b11) || ((1 << AWSIZE) > DW / 8);
          m_mode  = 1;
        end
        1: if (WVALID && mem_ready) begin
          m_cur = beat_addr(m_addr0, m_len, m_size, m_burst, m_beat);
          if (!in_win(m_cur)) m_err = 1'b1;
          if (WLAST != (m_beat == m_len)) m_err = 1'b1;
          if (m_beat == m_len) m_mode = 2;
          else m_beat++;
        end
        default: if (BREADY) m_mode = 0;
      endcase
    end
  end

  longint wl_addr[$];
  longint wl_data[$];
  int     n_beats;
  int     aw_cyc, last_beat_cyc, bv_cyc;
  bit     bv_seen;
  logic [1:0] got_bresp;
  logic [7:0] got_bid;
  longint c_addr;
  bit     c_iw;

  always @(negedge ACLK) begin
    if (chk_en) begin
      chk("awready", AWREADY, (m_mode == 0) && !stall && !ARESETn);
      chk("wready", WREADY, (m_mode == 1) && mem_ready);
      chk("busy", busy, m_mode != 0);
      chk("bvalid", BVALID, m_mode == 2);
      if (m_mode == 1) begin
        c_addr = beat_addr(m_addr0, m_len, m_size, m_burst, m_beat);
        c_iw   = in_win(c_addr);
        chk("mem_addr", mem_addr, c_addr);
        chk("mem_we", mem_we, WVALID && c_iw && mem_ready);
        chk("mem_wstrb", mem_wstrb, c_iw ? WSTRB : 4'h0);
        chk("mem_wdata", mem_wdata, WDATA);
      end else begin
        chk("mem_we_idle", mem_we, 1'b0);
      end
      if (m_mode == 2) begin
        chk("bid", BID, m_id);
        chk("bresp", BRESP, m_err ? 2'b10 : 2'b00);
      end
      if (mem_we) begin
        wl_addr.push_back(longint'(mem_addr));
        wl_data.push_back(longint'(mem_wdata));
      end
      if (WVALID && WREADY) begin
        n_beats++;
        last_beat_cyc = cyc;
      end
      if (AWVALID && AWREADY) aw_cyc = cyc;
      if (BVALID && !bv_seen) begin
        bv_seen   = 1'b1;
        bv_cyc    = cyc;
        got_bresp = BRESP;
        got_bid   = BID;
      end
    end
  end

  task automatic clr_log();
    wl_addr.delete();
    wl_data.delete();
    n_beats = 0;
    bv_seen = 1'b0;
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok = 1'b0;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (AWREADY) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge ACLK);
    #1;
    AWVALID = 1'b0;
    chk("aw_handshake", ok, 1'b1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    bit ok = 1'b0;
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (WREADY) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge ACLK);
    #1;
    WVALID = 1'b0;
    WLAST  = 1'b0;
    chk("w_handshake", ok, 1'b1);
  endtask

  task automatic wait_b();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (BVALID) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge ACLK);
    #1;
    chk("b_handshake", ok, 1'b1);
  endtask

  task automatic chk_addrs(input string nm, input longint exp[$]);
    chk({nm, "_count"}, wl_addr.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < wl_addr.size()) chk({nm, "_addr"}, wl_addr[i], exp[i]);
    end
  endtask

  initial begin
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [31:0] r_addr;

    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    chk_en = 1'b1;
    @(negedge ACLK);
    chk("rst_awready", AWREADY, 1'b0);
    chk("rst_wready", WREADY, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_bid", BID, 8'h00);
    chk("rst_bresp", BRESP, 2'b00);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_wstrb", mem_wstrb, 4'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b0;
    @(negedge ACLK);
    chk("post_rst_awready", AWREADY, 1'b1);
    @(posedge ACLK);
    #1;

    // Model pinning against hand-derived addresses.
    chk("model_wrap_b2", beat_addr(64'h38, 3, 2, 2, 2), 64'h30);
    chk("model_incr_b3", beat_addr(64'h100, 3, 2, 1, 3), 64'h10C);
    chk("model_fixed_b3", beat_addr(64'h44, 3, 2, 0, 3), 64'h44);

    // Single write and minimum latency.
    clr_log();
    send_aw(8'h5A, 32'h10, 8'd0, 3'd2, 2'b01);
    send_w(32'hDEADBEEF, 4'hF, 1'b1);
    wait_b();
    chk_addrs("single", '{64'h10});
    if (wl_data.size() > 0) chk("single_data", wl_data[0], 64'hDEADBEEF);
    chk("single_bresp", got_bresp, 2'b00);
    chk("single_bid", got_bid, 8'h5A);
    chk("single_latency", bv_cyc - aw_cyc, 2);

    // INCR burst.
    clr_log();
    send_aw(8'h01, 32'h100, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) send_w($urandom, 4'hF, i == 3);
    wait_b();
    chk_addrs("incr", '{64'h100, 64'h104, 64'h108, 64'h10C});
    chk("incr_b_after_last", bv_cyc - last_beat_cyc, 1);
    chk("incr_bresp", got_bresp, 2'b00);

    // WRAP burst.
    clr_log();
    send_aw(8'h02, 32'h38, 8'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++) send_w($urandom, 4'hF, i == 3);
    wait_b();
    chk_addrs("wrap", '{64'h38, 64'h3C, 64'h30, 64'h34});

    // Memory backpressure mid-burst.
    clr_log();
    send_aw(8'h03, 32'h200, 8'd3, 3'd2, 2'b01);
    send_w(32'hA0, 4'hF, 1'b0);
    send_w(32'hA1, 4'hF, 1'b0);
    WDATA = 32'hA2; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      chk("bp_wready", WREADY, 1'b0);
      @(posedge ACLK);
      #1;
    end
    mem_ready = 1'b1;
    send_w(32'hA2, 4'hF, 1'b0);
    send_w(32'hA3, 4'hF, 1'b1);
    wait_b();
    chk_addrs("bp", '{64'h200, 64'h204, 64'h208, 64'h20C});
    chk("bp_beats", n_beats, 4);

    // Out-of-window address.
    clr_log();
    send_aw(8'h04, 32'h10000, 8'd0, 3'd2, 2'b01);
    send_w(32'h1234, 4'hF, 1'b1);
    wait_b();
    chk("oow_writes", wl_addr.size(), 0);
    chk("oow_beats", n_beats, 1);
    chk("oow_bresp", got_bresp, 2'b10);

    // Early WLAST.
    clr_log();
    send_aw(8'h05, 32'h40, 8'd1, 3'd2, 2'b01);
    send_w(32'h1, 4'hF, 1'b1);
    send_w(32'h2, 4'hF, 1'b1);
    wait_b();
    chk("wlast_beats", n_beats, 2);
    chk("wlast_bresp", got_bresp, 2'b10);
    chk("wlast_bid", got_bid, 8'h05);

    // Stall holds off AW.
    clr_log();
    stall = 1'b1;
    AWID = 8'h06; AWADDR = 32'h80; AWLEN = 8'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("stall_awready", AWREADY, 1'b0);
      @(posedge ACLK);
      #1;
    end
    stall = 1'b0;
    send_aw(8'h06, 32'h80, 8'd0, 3'd2, 2'b01);
    send_w(32'h66, 4'h3, 1'b1);
    wait_b();
    chk_addrs("stall", '{64'h80});
    chk("stall_bresp", got_bresp, 2'b00);

    // Reset in the middle of a burst.
    clr_log();
    send_aw(8'h07, 32'h300, 8'd3, 3'd2, 2'b01);
    send_w(32'h77, 4'hF, 1'b0);
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_bvalid", BVALID, 1'b0);
    ARESETn = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      @(posedge ACLK);
      #1;
      r_burst = 2'($urandom % 4);
      r_size  = 3'($urandom % 4);
      if (r_burst == 2'b10) r_len = 8'((1 << ($urandom % 3 + 1)) - 1);
      else r_len = 8'($urandom % 8);
      r_addr = $urandom % 32'h12000;
      if (r_burst == 2'b10) r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
      AWVALID   = ($urandom % 4) == 0;
      AWID      = 8'($urandom);
      AWADDR    = r_addr;
      AWLEN     = r_len;
      AWSIZE    = r_size;
      AWBURST   = r_burst;
      WVALID    = ($urandom % 3) != 0;
      WDATA     = $urandom;
      WSTRB     = 4'($urandom);
      WLAST     = ((m_mode == 1) && (m_beat == m_len)) ^ (($urandom % 10) == 0);
      BREADY    = ($urandom % 2) == 0;
      stall     = ($urandom % 5) == 0;
      mem_ready = ($urandom % 4) != 0;
      ARESETn   = ($urandom % 500) == 0;
    end

    @(posedge ACLK);
    #1;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1; stall = 1'b0; mem_ready = 1'b1;
    ARESETn = 1'b0;
    repeat (20) @(posedge ACLK);
    #1;
    chk("final_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
